// File: rtl/trace_tx_if.sv
// Beat-stream interface for trace_tx: valid/ready handshake carrying 32-bit beats.
interface trace_tx_if;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/trace_tx.sv
// trace_tx: captures datapath state into two-beat trace records, buffers them
// in a record FIFO and streams them out over a valid/ready beat interface.
// Optional build macro TRACE_SKIP_STALL_EN: when defined, captures taken with
// stall=1 are ignored entirely.
module trace_tx #(
   parameter int DEPTH = 8,
   parameter int SEQ_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_en,
   input  logic [31:0]       pc_val,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic              stall,
   trace_tx_if.master        beat,
   output logic              overflow,
   output logic [7:0]        drop_count
);

   localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

   typedef enum logic {BEAT0, BEAT1} beat_t;

   // record storage: beat0 (pc) and beat1 (metadata) kept side by side
   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      meta_mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   beat_t            beat_q, beat_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drop_q, drop_d;

   logic             cap_take, full, out_vld, xfer, free, wr, drop;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // capture qualification, handshake decode and next-state computation
   always_comb begin
`ifdef TRACE_SKIP_STALL_EN
      cap_take = cap_en & ~stall;
`else
      cap_take = cap_en;
`endif
      full    = (cnt_q == FULL_CNT);
      out_vld = (cnt_q != '0);
      xfer    = out_vld & beat.out_ready;
      free    = xfer & (beat_q == BEAT1);
      // a full FIFO can still accept when its head record leaves this cycle
      wr      = cap_take & (~full | free);
      drop    = cap_take & full & ~free;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      beat_d   = beat_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;

      if (wr) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         seq_d    = seq_q + SEQ_ONE;
      end
      if (free) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (wr && !free) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (free && !wr) begin
         cnt_d = cnt_q - CNT_ONE;
      end
      if (xfer) begin
         beat_d = (beat_q == BEAT0) ? BEAT1 : BEAT0;
      end
      if (drop) begin
         ovf_d  = 1'b1;
         drop_d = sat_inc8(drop_q);
      end
   end

   // record write into storage; contents need no reset since pointers do
   always_ff @(posedge clk) begin
      if (wr) begin
         pc_mem[wr_ptr_q]   <= pc_val;
         meta_mem[wr_ptr_q] <= {stall, rs, rt, rd, seq_q};
      end
   end

   // control state update with synchronous reset taking priority
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         beat_q   <= BEAT0;
         seq_q    <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         beat_q   <= beat_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   assign beat.out_valid = out_vld;
   assign beat.out_data  = !out_vld          ? 32'h0 :
                           (beat_q == BEAT0) ? pc_mem[rd_ptr_q] : meta_mem[rd_ptr_q];
   assign overflow       = ovf_q;
   assign drop_count     = drop_q;

endmodule

// File: tb/tb_trace_tx.sv
// Self-checking bench for trace_tx: queue-based reference model feeds a
// scoreboard that a free-running monitor drains on every beat transfer.
module tb_trace_tx;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cap_en = 1'b0;
   logic [31:0] pc_val = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic        stall = 1'b0;
   logic        overflow;
   logic [7:0]  drop_count;

   trace_tx_if bif();

   trace_tx #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
      .clk(clk), .rst(rst), .cap_en(cap_en), .pc_val(pc_val),
      .rs(rs), .rt(rt), .rd(rd), .stall(stall),
      .beat(bif), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] sb[$];
   int          m_beats = 0;
   logic [15:0] m_seq = '0;
   logic        m_ovf = 1'b0;
   int          m_drop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock of stimulus plus the model's view of what that edge does
   task automatic step(input bit cap, input logic [31:0] pc, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] c, input bit st,
                       input bit rdy, input bit r);
      bit xfer, b1, take, acc, drp;
      int recs;
      @(negedge clk);
      rst = r; cap_en = cap; pc_val = pc; rs = a; rt = b; rd = c; stall = st;
      bif.out_ready = rdy;
      xfer = rdy && (m_beats > 0);
      b1   = xfer && (m_beats % 2 == 1);
      recs = (m_beats + 1) / 2;
`ifdef TRACE_SKIP_STALL_EN
      take = cap && !st;
`else
      take = cap;
`endif
      acc = take && ((recs < DEPTH) || b1);
      drp = take && !acc;
      @(posedge clk);
      #1;
      if (r) begin
         sb.delete();
         m_beats = 0; m_seq = '0; m_ovf = 1'b0; m_drop = 0;
      end else begin
         if (xfer) m_beats--;
         if (acc) begin
            sb.push_back(pc);
            sb.push_back({st, a, b, c, m_seq});
            m_beats += 2;
            m_seq++;
         end
         if (drp) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
         end
      end
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, rdy, 1'b0);
   endtask

   task automatic cap_rand(input bit rdy);
      step(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), rdy, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (m_beats > 0 && n < 200) begin
         idle(1'b1);
         n++;
      end
      checks++;
      if (m_beats != 0) begin
         errors++;
         $display("FAIL drain_timeout: beats left %0d required 0", m_beats);
      end
      idle(1'b1);
   endtask

   // monitor: samples just before each rising edge, pops and compares on transfer
   always begin
      logic [31:0] exp;
      @(negedge clk);
      #4;
      if (rst !== 1'b1) begin
         chk("out_valid", 32'(bif.out_valid), 32'(sb.size() != 0));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("drop_count", 32'(drop_count), 32'(m_drop));
         if (bif.out_valid === 1'b1 && bif.out_ready === 1'b1 && sb.size() != 0) begin
            exp = sb.pop_front();
            chk("beat", bif.out_data, exp);
         end
      end
   end

   initial begin
      int mode;
      bif.out_ready = 1'b0;

      // reset state
      step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      chk("rst_valid", 32'(bif.out_valid), 32'h0);
      chk("rst_data", bif.out_data, 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_drop", 32'(drop_count), 32'h0);

      // single capture, streamed out immediately
      step(1'b1, 32'h0000_0040, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
      chk("single_beat0", bif.out_data, 32'h0000_0040);
      idle(1'b1);
      chk("single_beat1", bif.out_data, 32'h0443_0000);
      drain();

      // backpressure holds beat0 stable
      step(1'b1, 32'h0000_0040, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
      repeat (5) begin
         idle(1'b0);
         chk("hold_data", bif.out_data, 32'h0000_0040);
      end
      drain();

      // overflow: ten captures into a stalled FIFO
      for (int i = 0; i < 10; i++) cap_rand(1'b0);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_drop", 32'(drop_count), 32'd2);
      // full + beat1 leaving in the same cycle: accepted
      idle(1'b1);
      cap_rand(1'b1);
      chk("fullfree_drop", 32'(drop_count), 32'd2);
      drain();

      // reset with a record in flight
      cap_rand(1'b0);
      idle(1'b1);
      step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      idle(1'b0);
      chk("midrst_valid", 32'(bif.out_valid), 32'h0);
      chk("midrst_ovf", 32'(overflow), 32'h0);
      cap_rand(1'b1);
      drain();

      // stall filter: stall=1 then stall=0
      step(1'b1, 32'h0000_1000, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h0000_2000, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0);
`ifdef TRACE_SKIP_STALL_EN
      chk("stall_recs", 32'(m_beats), 32'd2);
`else
      chk("stall_recs", 32'(m_beats), 32'd4);
`endif
      drain();

      // drop counter saturation
      step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 270; i++) cap_rand(1'b0);
      chk("drop_sat", 32'(drop_count), 32'd255);
      drain();

      // randomized traffic with varying backpressure and sporadic resets
      mode = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) mode = $urandom_range(0, 2);
         if ($urandom_range(0, 399) == 0) begin
            step(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'($urandom), 1'b1);
         end else begin
            step(1'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                 ($urandom_range(0, 3) == 0),
                 (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 9) < 7)
                                                  : ($urandom_range(0, 9) < 2),
                 1'b0);
         end
      end
      cap_en = 1'b0;
      drain();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trace_tx.md
TRACE_TX -- requirements
Module: trace_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, record-FIFO depth in records (power of two, 2..64).
REQ-002 SHALL have parameter SEQ_W, default 16, sequence-counter width (fixed 16 for the packing in REQ-014).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port cap_en  input  1  capture enable, samples the datapath state this cycle.
REQ-006 SHALL have port pc_val  input  32  datapath program counter.
REQ-007 SHALL have port rs  input  5  source register index.
REQ-008 SHALL have port rt  input  5  target register index.
REQ-009 SHALL have port rd  input  5  destination register index.
REQ-010 SHALL have port stall  input  1  datapath stall flag.
REQ-011 SHALL have port out_valid, out_data, out_ready  output 1 / output 32 / input 1  beat stream; a beat transfers when out_valid and out_ready are both 1 on a posedge.
REQ-012 SHALL have port overflow  output  1  sticky, set when any record is dropped.
REQ-013 SHALL have port drop_count  output  8  number of dropped records, saturating.

Function
REQ-014 A record SHALL be two beats: beat0 = pc_val; beat1 = {stall, rs, rt, rd, seq[15:0]}, with stall at bit 31 and seq at bits 15:0.
REQ-015 On a posedge with cap_en=1, the inputs SHALL be latched as one record, and seq SHALL be the count of records accepted since reset, starting at 0 and wrapping at 16'hFFFF to 0.
REQ-016 Records SHALL be held in a FIFO of DEPTH entries with wrapping read/write pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-017 out_valid SHALL rise on the cycle after a record is written into an empty FIFO, so capture-to-first-beat latency is 1 cycle.
REQ-018 Beats SHALL leave in order beat0 then beat1; the FIFO entry SHALL be freed only when beat1 transfers.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_valid SHALL be held stable.
REQ-020 out_valid SHALL be 0 whenever the FIFO is empty; out_data is don't-care then.
REQ-021 With out_ready held at 1, beats SHALL stream back-to-back: 2 cycles per record, no bubbles.
REQ-022 Capture with FIFO full and no beat1 transfer in the same cycle: the record SHALL be dropped, seq SHALL NOT advance, overflow SHALL set, and drop_count SHALL increment and saturate at 255.
REQ-023 Capture with FIFO full while beat1 transfers in the same cycle: the record SHALL be accepted, with no drop.
REQ-024 Simultaneous write and free on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-025 overflow and drop_count SHALL clear only on rst.

Reset
REQ-026 When rst=1 at a posedge: FIFO emptied, pointers=0, beat select=beat0, seq=0, out_valid=0, out_data=0, overflow=0, drop_count=0.
REQ-027 rst SHALL take priority over capture and transfer in the same cycle, and a record in flight (beat0 sent, beat1 pending) SHALL be discarded.
REQ-028 After rst deasserts, the first capture SHALL carry seq=0.

Configuration
REQ-029 Macro TRACE_SKIP_STALL_EN defined: captures with stall=1 SHALL be ignored entirely (no write, no seq advance, no drop count).
REQ-030 Macro TRACE_SKIP_STALL_EN undefined: stall cycles SHALL be captured like any other, with bit 31 of beat1 recording stall.

Verification
REQ-031 Single capture: pc_val=32'h0000_0040, rs=1, rt=2, rd=3, stall=0, out_ready=1 -> cycle+1 beat 32'h0000_0040; cycle+2 beat 32'h0443_0000.
REQ-032 Backpressure: out_ready=0 for 5 cycles after valid -> out_data stays 32'h0000_0040; release -> beat1 transfers on the 2nd ready cycle.
REQ-033 Overflow, DEPTH=8, out_ready=0: 10 consecutive captures -> 8 stored, overflow=1, drop_count=2; drain shows seq 0..7.
REQ-034 Full+free same cycle: full FIFO, beat1 transfers as cap_en=1 -> record accepted, drop_count unchanged.
REQ-035 Reset mid-record: rst after beat0 transfer -> out_valid=0 next cycle; next capture emits seq=0.
REQ-036 Stall filter: with TRACE_SKIP_STALL_EN, capture stall=1 then stall=0 -> exactly one record, seq=0, bit31=0; without the macro -> two records, seq 0 and 1.
